// File: rtl/bus_one_dma_master_2_one_memory_slave.sv
// DMA master plus word-addressed memory slave joined by an internal AXI-style
// bus. Page-fault requests burst-read memory into the line buffer; write-back
// requests burst-write the line buffer out to memory. One transfer at a time.
//
// Handshake rule on every bus channel (AR, R, AW, W, B): a beat transfers on
// the rising edge where valid and ready are both 1. A source holds valid and
// its payload stable until that edge. Valid never depends on ready.
module bus_one_dma_master_2_one_memory_slave #(
  parameter int ADDR_WIDTH           = 32,
  parameter int READ_CHANNEL_WIDTH   = 32,
  parameter int READ_BURST_LEN       = 8,
  parameter int WRITE_CHANNEL_WIDTH  = 32,
  parameter int WRITE_BURST_LEN      = 8,
  parameter int ASYNCFIFO_ADDR_WIDTH = 3,
  parameter int MEM_WORDS            = 64
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst_n,
  input  logic                       dma_page_fault_happen,
  output logic                       dma_page_fault_done,
  input  logic [ADDR_WIDTH-1:0]      dma_page_fault_addr,
  input  logic [READ_BURST_LEN-1:0]  dma_page_fault_burst_len,
  input  logic                       dma_write_back_happen,
  output logic                       dma_write_back_done,
  input  logic [ADDR_WIDTH-1:0]      dma_write_back_addr,
  input  logic [WRITE_BURST_LEN-1:0] dma_write_back_burst_len
);

  localparam int LB_DEPTH = 1 << ASYNCFIFO_ADDR_WIDTH;
  localparam int MEM_AW   = $clog2(MEM_WORDS);
  localparam int LEN_W    = (READ_BURST_LEN > WRITE_BURST_LEN) ? READ_BURST_LEN : WRITE_BURST_LEN;
  // Both data channels are fixed at 32 bits, so one data width serves both.
  localparam int DATA_W   = READ_CHANNEL_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB_AW = 3'd1,
    WB_W  = 3'd2,
    WB_B  = 3'd3,
    PF_AR = 3'd4,
    PF_R  = 3'd5,
    DONE  = 3'd6
  } dma_state_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_W    = 3'd1,
    S_WEND = 3'd2,
    S_B    = 3'd3,
    S_R    = 3'd4
  } slv_state_t;

  // ---------------- internal bus ----------------
  logic                  aw_valid, aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [LEN_W-1:0]      aw_len;
  logic                  w_valid, w_ready, w_last;
  logic [DATA_W-1:0]     w_data;
  logic                  b_valid, b_ready;
  logic                  ar_valid, ar_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [LEN_W-1:0]      ar_len;
  logic                  r_valid, r_ready, r_last;
  logic [DATA_W-1:0]     r_data;

  // ---------------- DMA master ----------------
  dma_state_t                      state, state_nxt;
  logic                            is_wb;
  logic [ADDR_WIDTH-1:0]           req_addr;
  logic [LEN_W-1:0]                req_len;
  logic [LEN_W-1:0]                beat_cnt;
  logic                            wb_armed, pf_armed;
  logic [DATA_W-1:0]               line_buf [LB_DEPTH];
  logic [ASYNCFIFO_ADDR_WIDTH-1:0] lb_idx;
  logic                            wb_go, pf_go;

  // Write-back has priority when both requests are pending together.
  assign wb_go  = (state == IDLE) && dma_write_back_happen && wb_armed;
  assign pf_go  = (state == IDLE) && dma_page_fault_happen && pf_armed && !wb_go;
  assign lb_idx = beat_cnt[ASYNCFIFO_ADDR_WIDTH-1:0];

  assign aw_addr = req_addr;
  assign aw_len  = req_len;
  assign ar_addr = req_addr;
  assign ar_len  = req_len;
  assign b_ready = 1'b1;

  assign dma_write_back_done = (state == DONE) && is_wb;
  assign dma_page_fault_done = (state == DONE) && !is_wb;

  // Master state register.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Master next-state and bus-side outputs.
  always_comb begin
    state_nxt = state;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    w_last    = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    w_data    = line_buf[lb_idx];
    case (state)
      IDLE: begin
        if (wb_go)      state_nxt = WB_AW;
        else if (pf_go) state_nxt = PF_AR;
      end
      WB_AW: begin
        aw_valid = 1'b1;
        if (aw_ready) state_nxt = WB_W;
      end
      WB_W: begin
        w_valid = 1'b1;
        w_last  = (beat_cnt == req_len);
        if (w_ready && w_last) state_nxt = WB_B;
      end
      WB_B: begin
        if (b_valid) state_nxt = DONE;
      end
      PF_AR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_nxt = PF_R;
      end
      PF_R: begin
        r_ready = 1'b1;
        if (r_valid && r_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latching, beat counting and line-buffer fill.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      is_wb    <= 1'b0;
      req_addr <= '0;
      req_len  <= '0;
      beat_cnt <= '0;
      for (int i = 0; i < LB_DEPTH; i++) line_buf[i] <= '0;
    end else begin
      if (state == IDLE) begin
        beat_cnt <= '0;
        if (wb_go) begin
          is_wb    <= 1'b1;
          req_addr <= dma_write_back_addr;
          req_len  <= LEN_W'(dma_write_back_burst_len);
        end else if (pf_go) begin
          is_wb    <= 1'b0;
          req_addr <= dma_page_fault_addr;
          req_len  <= LEN_W'(dma_page_fault_burst_len);
        end
      end
      if (w_valid && w_ready) beat_cnt <= beat_cnt + 1'b1;
      if (r_valid && r_ready) begin
        line_buf[lb_idx] <= r_data;
        beat_cnt         <= beat_cnt + 1'b1;
      end
    end
  end

  // Armed flags: re-arm only after the request level is seen low, so a held
  // level is served once.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      wb_armed <= 1'b0;
      pf_armed <= 1'b0;
    end else begin
      if (!dma_write_back_happen) wb_armed <= 1'b1;
      else if (wb_go)             wb_armed <= 1'b0;
      if (!dma_page_fault_happen) pf_armed <= 1'b1;
      else if (pf_go)             pf_armed <= 1'b0;
    end
  end

  // ---------------- memory slave ----------------
  slv_state_t        s_state, s_state_nxt;
  logic [MEM_AW-1:0] s_addr;
  logic [LEN_W-1:0]  s_len;
  logic [LEN_W-1:0]  s_cnt;
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic              s_last;

  // The slave tracks its own beat count from the latched length.
  assign s_last   = (s_cnt == s_len);
  assign aw_ready = (s_state == S_IDLE);
  assign ar_ready = (s_state == S_IDLE) && !aw_valid;
  assign w_ready  = (s_state == S_W);
  assign b_valid  = (s_state == S_B);
  assign r_valid  = (s_state == S_R);
  assign r_last   = (s_state == S_R) && s_last;
  assign r_data   = mem[s_addr];

  // Slave state register.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) s_state <= S_IDLE;
    else            s_state <= s_state_nxt;
  end

  // Slave next state. S_WEND is the one-cycle gap between the last write
  // beat and the write response.
  always_comb begin
    s_state_nxt = s_state;
    case (s_state)
      S_IDLE: begin
        if (aw_valid)      s_state_nxt = S_W;
        else if (ar_valid) s_state_nxt = S_R;
      end
      S_W:     if (w_valid && s_last) s_state_nxt = S_WEND;
      S_WEND:  s_state_nxt = S_B;
      S_B:     if (b_ready) s_state_nxt = S_IDLE;
      S_R:     if (r_ready && s_last) s_state_nxt = S_IDLE;
      default: s_state_nxt = S_IDLE;
    endcase
  end

  // Slave address/count tracking and memory writes. The word index is a
  // MEM_AW-bit counter, so bursts wrap modulo MEM_WORDS for free.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      s_addr <= '0;
      s_len  <= '0;
      s_cnt  <= '0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= DATA_W'(i);
    end else begin
      case (s_state)
        S_IDLE: begin
          s_cnt <= '0;
          if (aw_valid) begin
            s_addr <= aw_addr[MEM_AW+1:2];
            s_len  <= aw_len;
          end else if (ar_valid) begin
            s_addr <= ar_addr[MEM_AW+1:2];
            s_len  <= ar_len;
          end
        end
        S_W: begin
          if (w_valid) begin
            mem[s_addr] <= w_data;
            s_addr      <= s_addr + 1'b1;
            s_cnt       <= s_cnt + 1'b1;
          end
        end
        S_R: begin
          if (r_ready) begin
            s_addr <= s_addr + 1'b1;
            s_cnt  <= s_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte-offset and out-of-range address bits and WLAST are not needed by
  // the slave; fold them into one sink.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{aw_addr[ADDR_WIDTH-1:MEM_AW+2], aw_addr[1:0],
                             ar_addr[ADDR_WIDTH-1:MEM_AW+2], ar_addr[1:0], w_last};

endmodule

// File: tb/tb_bus_one_dma_master_2_one_memory_slave.sv
// Directed bench for the DMA master / memory slave bridge.
module tb_bus_one_dma_master_2_one_memory_slave;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n = 1'b0;
  logic        dma_page_fault_happen = 1'b0;
  logic        dma_page_fault_done;
  logic [31:0] dma_page_fault_addr = '0;
  logic [7:0]  dma_page_fault_burst_len = '0;
  logic        dma_write_back_happen = 1'b0;
  logic        dma_write_back_done;
  logic [31:0] dma_write_back_addr = '0;
  logic [7:0]  dma_write_back_burst_len = '0;

  int checks = 0;
  int passes = 0;

  bus_one_dma_master_2_one_memory_slave dut (
    .cpu_clk                  (cpu_clk),
    .cpu_rst_n                (cpu_rst_n),
    .dma_page_fault_happen    (dma_page_fault_happen),
    .dma_page_fault_done      (dma_page_fault_done),
    .dma_page_fault_addr      (dma_page_fault_addr),
    .dma_page_fault_burst_len (dma_page_fault_burst_len),
    .dma_write_back_happen    (dma_write_back_happen),
    .dma_write_back_done      (dma_write_back_done),
    .dma_write_back_addr      (dma_write_back_addr),
    .dma_write_back_burst_len (dma_write_back_burst_len)
  );

  // Clock and reset
  always #5 cpu_clk = ~cpu_clk;

  task automatic do_reset();
    @(negedge cpu_clk);
    cpu_rst_n = 1'b0;
    repeat (2) @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    @(negedge cpu_clk);
  endtask

  // Step n cycles, sampling both done outputs on each falling edge. Cycle 1
  // is the falling edge right after the edge that sees a freshly raised request.
  task automatic run_cycles(input int n, output int wb_n, output int wb_first,
                            output int pf_n, output int pf_first);
    wb_n = 0; wb_first = 0; pf_n = 0; pf_first = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge cpu_clk);
      if (dma_write_back_done) begin
        wb_n++;
        if (wb_first == 0) wb_first = i;
      end
      if (dma_page_fault_done) begin
        pf_n++;
        if (pf_first == 0) pf_first = i;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dma_write_back_done !== 1'b0) $display("FAIL reset_wb_done: got %0b expected 0", dma_write_back_done); else passes++;
    checks++; if (dma_page_fault_done !== 1'b0) $display("FAIL reset_pf_done: got %0b expected 0", dma_page_fault_done); else passes++;
    checks++; if (dut.state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", dut.state); else passes++;
    checks++; if (dut.mem[7] !== 32'd7) $display("FAIL reset_mem7: got %0d expected 7", dut.mem[7]); else passes++;
    for (int k = 0; k < 8; k++) begin
      checks++; if (dut.line_buf[k] !== 32'd0) $display("FAIL reset_lb%0d: got %0d expected 0", k, dut.line_buf[k]); else passes++;
    end
  endtask

  task automatic test_write_back_empty();
    int wb_n, wb_f, pf_n, pf_f, wb_n2, wb_f2, pf_n2, pf_f2;
    dma_write_back_addr = 32'd20;
    dma_write_back_burst_len = 8'd5;
    dma_write_back_happen = 1'b1;
    run_cycles(20, wb_n, wb_f, pf_n, pf_f);
    dma_write_back_happen = 1'b0;
    run_cycles(3, wb_n2, wb_f2, pf_n2, pf_f2);
    checks++; if (wb_n + wb_n2 !== 1) $display("FAIL wb_empty_pulses: got %0d expected 1", wb_n + wb_n2); else passes++;
    checks++; if (wb_f !== 10) $display("FAIL wb_empty_latency: got %0d expected 10", wb_f); else passes++;
    checks++; if (pf_n + pf_n2 !== 0) $display("FAIL wb_empty_pf_pulses: got %0d expected 0", pf_n + pf_n2); else passes++;
    for (int w = 5; w <= 10; w++) begin
      checks++; if (dut.mem[w] !== 32'd0) $display("FAIL wb_empty_mem%0d: got %0d expected 0", w, dut.mem[w]); else passes++;
    end
    checks++; if (dut.mem[11] !== 32'd11) $display("FAIL wb_empty_mem11: got %0d expected 11", dut.mem[11]); else passes++;
    checks++; if (dut.mem[4] !== 32'd4) $display("FAIL wb_empty_mem4: got %0d expected 4", dut.mem[4]); else passes++;
  endtask

  task automatic test_page_fault_then_write_back();
    int wb_n, wb_f, pf_n, pf_f;
    do_reset();
    dma_page_fault_addr = 32'd0;
    dma_page_fault_burst_len = 8'd7;
    dma_page_fault_happen = 1'b1;
    run_cycles(30, wb_n, wb_f, pf_n, pf_f);
    dma_page_fault_happen = 1'b0;
    checks++; if (pf_n !== 1) $display("FAIL pf_pulses: got %0d expected 1", pf_n); else passes++;
    checks++; if (wb_n !== 0) $display("FAIL pf_wb_pulses: got %0d expected 0", wb_n); else passes++;
    for (int k = 0; k < 8; k++) begin
      checks++; if (dut.line_buf[k] !== 32'(k)) $display("FAIL pf_lb%0d: got %0d expected %0d", k, dut.line_buf[k], k); else passes++;
    end
    dma_write_back_addr = 32'd128;
    dma_write_back_burst_len = 8'd7;
    dma_write_back_happen = 1'b1;
    run_cycles(30, wb_n, wb_f, pf_n, pf_f);
    dma_write_back_happen = 1'b0;
    checks++; if (wb_n !== 1) $display("FAIL wb32_pulses: got %0d expected 1", wb_n); else passes++;
    for (int k = 0; k < 8; k++) begin
      checks++; if (dut.mem[32+k] !== 32'(k)) $display("FAIL wb32_mem%0d: got %0d expected %0d", 32 + k, dut.mem[32+k], k); else passes++;
    end
    checks++; if (dut.mem[40] !== 32'd40) $display("FAIL wb32_mem40: got %0d expected 40", dut.mem[40]); else passes++;
  endtask

  task automatic test_wrap();
    int wb_n, wb_f, pf_n, pf_f;
    logic [31:0] exp_lb [4];
    exp_lb[0] = 32'd62; exp_lb[1] = 32'd63; exp_lb[2] = 32'd0; exp_lb[3] = 32'd1;
    @(negedge cpu_clk);
    dma_page_fault_addr = 32'd248;
    dma_page_fault_burst_len = 8'd3;
    dma_page_fault_happen = 1'b1;
    run_cycles(20, wb_n, wb_f, pf_n, pf_f);
    dma_page_fault_happen = 1'b0;
    checks++; if (pf_n !== 1) $display("FAIL wrap_pulses: got %0d expected 1", pf_n); else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++; if (dut.line_buf[k] !== exp_lb[k]) $display("FAIL wrap_lb%0d: got %0d expected %0d", k, dut.line_buf[k], exp_lb[k]); else passes++;
    end
    checks++; if (dut.line_buf[4] !== 32'd4) $display("FAIL wrap_lb4: got %0d expected 4", dut.line_buf[4]); else passes++;
  endtask

  task automatic test_simultaneous();
    int wb_n, wb_f, pf_n, pf_f;
    @(negedge cpu_clk);
    dma_write_back_addr = 32'd160;
    dma_write_back_burst_len = 8'd1;
    dma_page_fault_addr = 32'd256;
    dma_page_fault_burst_len = 8'd0;
    dma_write_back_happen = 1'b1;
    dma_page_fault_happen = 1'b1;
    run_cycles(40, wb_n, wb_f, pf_n, pf_f);
    dma_write_back_happen = 1'b0;
    dma_page_fault_happen = 1'b0;
    checks++; if (wb_n !== 1) $display("FAIL sim_wb_pulses: got %0d expected 1", wb_n); else passes++;
    checks++; if (pf_n !== 1) $display("FAIL sim_pf_pulses: got %0d expected 1", pf_n); else passes++;
    checks++; if ((wb_f > 0 && wb_f < pf_f) !== 1'b1) $display("FAIL sim_order: got wb at %0d pf at %0d expected wb first", wb_f, pf_f); else passes++;
    checks++; if (dut.mem[40] !== 32'd62) $display("FAIL sim_mem40: got %0d expected 62", dut.mem[40]); else passes++;
    checks++; if (dut.mem[41] !== 32'd63) $display("FAIL sim_mem41: got %0d expected 63", dut.mem[41]); else passes++;
    checks++; if (dut.line_buf[0] !== 32'd0) $display("FAIL sim_lb0: got %0d expected 0", dut.line_buf[0]); else passes++;
    checks++; if (dut.line_buf[1] !== 32'd63) $display("FAIL sim_lb1: got %0d expected 63", dut.line_buf[1]); else passes++;
  endtask

  task automatic test_reset_mid_burst();
    int wb_n, wb_f, pf_n, pf_f, wb_n2, wb_f2, pf_n2, pf_f2;
    bit seen_w;
    seen_w = 1'b0;
    @(negedge cpu_clk);
    dma_write_back_addr = 32'd20;
    dma_write_back_burst_len = 8'd7;
    dma_write_back_happen = 1'b1;
    for (int i = 0; i < 10 && !seen_w; i++) begin
      @(negedge cpu_clk);
      if (dut.state == 3'd2) seen_w = 1'b1;
    end
    checks++; if (seen_w !== 1'b1) $display("FAIL mid_reach_wb_w: got %0b expected 1", seen_w); else passes++;
    @(negedge cpu_clk);
    cpu_rst_n = 1'b0;
    dma_write_back_happen = 1'b0;
    run_cycles(2, wb_n, wb_f, pf_n, pf_f);
    cpu_rst_n = 1'b1;
    run_cycles(3, wb_n2, wb_f2, pf_n2, pf_f2);
    checks++; if (wb_n + wb_n2 + pf_n + pf_n2 !== 0) $display("FAIL mid_no_done: got %0d expected 0", wb_n + wb_n2 + pf_n + pf_n2); else passes++;
    checks++; if (dut.state !== 3'd0) $display("FAIL mid_state: got %0d expected 0", dut.state); else passes++;
    checks++; if (dut.mem[5] !== 32'd5) $display("FAIL mid_mem5: got %0d expected 5", dut.mem[5]); else passes++;
    checks++; if (dut.mem[40] !== 32'd40) $display("FAIL mid_mem40: got %0d expected 40", dut.mem[40]); else passes++;
    checks++; if (dut.line_buf[1] !== 32'd0) $display("FAIL mid_lb1: got %0d expected 0", dut.line_buf[1]); else passes++;
    dma_page_fault_addr = 32'd40;
    dma_page_fault_burst_len = 8'd2;
    dma_page_fault_happen = 1'b1;
    run_cycles(20, wb_n, wb_f, pf_n, pf_f);
    dma_page_fault_happen = 1'b0;
    checks++; if (pf_n !== 1) $display("FAIL mid_after_pulses: got %0d expected 1", pf_n); else passes++;
    for (int k = 0; k < 3; k++) begin
      checks++; if (dut.line_buf[k] !== 32'(10 + k)) $display("FAIL mid_after_lb%0d: got %0d expected %0d", k, dut.line_buf[k], 10 + k); else passes++;
    end
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_write_back_empty();
    test_page_fault_then_write_back();
    test_wrap();
    test_simultaneous();
    test_reset_mid_burst();
    repeat (2) @(negedge cpu_clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
